b06_resp_misr: RTL and testbench

Response compactor placed directly downstream of the `b06` interrupt-handler core in the conquest test harness. Each cycle it is strobed, it folds the core's outputs (`cc_mux`, `uscite`, `enable_count`, `ackout`) into a 16-bit multiple-input signature register (MISR). After a programmable number of strobed samples it freezes the signature and flags completion. A bench checks one signature instead of a per-cycle trace.

---
 rtl/b06_resp_misr.sv | 137 +++++++++++++
 tb/tb_b06_resp_misr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/b06_resp_misr.sv
// Response MISR for the b06 core: folds strobed core outputs into a signature over a fixed window.
// Optional rising-edge counter on ackout is built when B06_MISR_EDGECNT_EN is defined.
module b06_resp_misr #(
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'hD008,
    parameter logic [SIG_W-1:0] SEED   = 16'h0000,
    parameter int               WINDOW = 10,
    localparam int              CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             __obs,
    input  logic [1:0]       cc_mux,
    input  logic [1:0]       uscite,
    input  logic             enable_count,
    input  logic             ackout,
    input  logic [SIG_W-1:0] expected,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] sample_count,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [7:0]       ack_edges
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [SIG_W-1:0] sig_r, sig_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic [5:0]       in6_s;

    // One Galois MISR step: shift, conditional feedback, fold in the zero-extended input.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [5:0]       d);
        logic [SIG_W-1:0] fb;
        fb = s[SIG_W-1] ? POLY : {SIG_W{1'b0}};
        return {s[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-6){1'b0}}, d};
    endfunction

    assign in6_s = {ackout, enable_count, uscite, cc_mux};

    // Next-state, signature and sample-count logic.
    always_comb begin
        state_s = state_r;
        sig_s   = sig_r;
        count_s = count_r;
        case (state_r)
            IDLE, DONE: begin
                // A start wins over a coincident strobe; that cycle is not sampled.
                if (start) begin
                    state_s = RUN;
                    sig_s   = SEED;
                    count_s = {CNT_W{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (__obs) begin
                    sig_s   = misr_step(sig_r, in6_s);
                    count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_r == CNT_W'(WINDOW - 1)) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
                sig_s   = SEED;
                count_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, signature and count registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            sig_r   <= SEED;
            count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            sig_r   <= sig_s;
            count_r <= count_s;
        end
    end

    assign signature    = sig_r;
    assign sample_count = count_r;
    assign busy         = (state_r == RUN);
    assign done         = (state_r == DONE);
    assign match        = done && (sig_r == expected);

`ifdef B06_MISR_EDGECNT_EN
    logic       ack_q_r;
    logic [7:0] edge_cnt_r;
    logic       enter_run_s;

    assign enter_run_s = (state_r != RUN) && (state_s == RUN);

    // Saturating count of ackout rising edges while running, independent of the strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_q_r    <= 1'b0;
            edge_cnt_r <= 8'h00;
        end else if (enter_run_s) begin
            ack_q_r    <= 1'b0;
            edge_cnt_r <= 8'h00;
        end else if (state_r == RUN) begin
            ack_q_r <= ackout;
            if (ackout && !ack_q_r && (edge_cnt_r != 8'hFF)) begin
                edge_cnt_r <= edge_cnt_r + 8'd1;
            end else begin
                edge_cnt_r <= edge_cnt_r;
            end
        end else begin
            ack_q_r    <= ack_q_r;
            edge_cnt_r <= edge_cnt_r;
        end
    end

    assign ack_edges = edge_cnt_r;
`else
    assign ack_edges = 8'h00;
`endif

endmodule

// File: tb/tb_b06_resp_misr.sv
// Scoreboard bench for b06_resp_misr: two instances (SEED 0000 and 8000) share stimulus.
module tb_b06_resp_misr;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        obs = 1'b0;
    logic [1:0]  cc_mux = 2'b00;
    logic [1:0]  uscite = 2'b00;
    logic        enable_count = 1'b0;
    logic        ackout = 1'b0;
    logic [15:0] expected = 16'h0000;

    logic [15:0] sig0, sig1;
    logic [3:0]  cnt0, cnt1;
    logic        busy0, busy1, done0, done1, match0, match1;
    logic [7:0]  edges0, edges1;

    always #5 clock = ~clock;

    b06_resp_misr dut0 (
        .clock(clock), .reset(reset), .start(start), .__obs(obs),
        .cc_mux(cc_mux), .uscite(uscite), .enable_count(enable_count), .ackout(ackout),
        .expected(expected), .signature(sig0), .sample_count(cnt0),
        .busy(busy0), .done(done0), .match(match0), .ack_edges(edges0)
    );

    b06_resp_misr #(.SEED(16'h8000)) dut1 (
        .clock(clock), .reset(reset), .start(start), .__obs(obs),
        .cc_mux(cc_mux), .uscite(uscite), .enable_count(enable_count), .ackout(ackout),
        .expected(expected), .signature(sig1), .sample_count(cnt1),
        .busy(busy1), .done(done1), .match(match1), .ack_edges(edges1)
    );

    typedef struct {
        logic [15:0] sig0;
        logic [15:0] sig1;
        logic [3:0]  cnt;
        logic        busy;
        logic        done;
        logic        match0;
        logic [7:0]  edges;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (0 idle, 1 run, 2 done); both instances share control flow.
    int          m_state = 0;
    logic [15:0] m_sig0 = 16'h0000;
    logic [15:0] m_sig1 = 16'h8000;
    logic [3:0]  m_cnt = 4'd0;
    logic        m_ackq = 1'b0;
    logic [7:0]  m_edges = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] mstep(input logic [15:0] s, input logic [5:0] d);
        logic [15:0] fb;
        fb = s[15] ? 16'hD008 : 16'h0000;
        return (s << 1) ^ fb ^ {10'd0, d};
    endfunction

    // Drive one cycle, advance the model, push the expectation, then pop and compare after the edge.
    task automatic cyc(input logic rst, input logic st, input logic ob, input logic [5:0] in6);
        exp_t e;
        exp_t g;
        reset = rst; start = st; obs = ob;
        cc_mux = in6[1:0]; uscite = in6[3:2]; enable_count = in6[4]; ackout = in6[5];
        if (rst) begin
            m_state = 0; m_sig0 = 16'h0000; m_sig1 = 16'h8000;
            m_cnt = 4'd0; m_ackq = 1'b0; m_edges = 8'h00;
        end else if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_sig0 = 16'h0000; m_sig1 = 16'h8000;
                m_cnt = 4'd0; m_ackq = 1'b0; m_edges = 8'h00;
            end
        end else begin
`ifdef B06_MISR_EDGECNT_EN
            if (in6[5] && !m_ackq && m_edges != 8'hFF) m_edges = m_edges + 8'd1;
            m_ackq = in6[5];
`endif
            if (ob) begin
                m_sig0 = mstep(m_sig0, in6);
                m_sig1 = mstep(m_sig1, in6);
                m_cnt  = m_cnt + 4'd1;
                if (m_cnt == 4'd10) m_state = 2;
            end
        end
        e.sig0 = m_sig0; e.sig1 = m_sig1; e.cnt = m_cnt;
        e.busy = (m_state == 1); e.done = (m_state == 2);
        e.match0 = (m_state == 2) && (m_sig0 == expected);
        e.edges = m_edges;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        g = exp_q.pop_front();
        check("sig0", {16'h0, sig0}, {16'h0, g.sig0});
        check("sig1", {16'h0, sig1}, {16'h0, g.sig1});
        check("count", {28'h0, cnt0}, {28'h0, g.cnt});
        check("busy", {31'h0, busy0}, {31'h0, g.busy});
        check("done", {31'h0, done0}, {31'h0, g.done});
        check("match", {31'h0, match0}, {31'h0, g.match0});
        check("edges", {24'h0, edges0}, {24'h0, g.edges});
    endtask

    logic [15:0] frozen;

    initial begin
        // Reset then idle with strobes.
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 6'd0);
        check("idle_sig", {16'h0, sig0}, 32'h0000);
        check("idle_busy", {31'h0, busy0}, 32'd0);

        // Feedback path on the SEED=8000 instance.
        cyc(1'b0, 1'b1, 1'b0, 6'd0);
        cyc(1'b0, 1'b0, 1'b1, 6'd0);
        check("feedback", {16'h0, sig1}, 32'h0000D008);

        // Basic accumulate from a fresh run.
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        cyc(1'b0, 1'b1, 1'b0, 6'd0);
        cyc(1'b0, 1'b0, 1'b1, 6'b000001);
        check("acc1", {16'h0, sig0}, 32'h00000001);
        cyc(1'b0, 1'b0, 1'b1, 6'b000001);
        check("acc2", {16'h0, sig0}, 32'h00000003);

        // Window with gaps and an ignored start, ackout-only samples.
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        cyc(1'b0, 1'b1, 1'b0, 6'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                frozen = sig0;
                cyc(1'b0, 1'b0, 1'b0, 6'b100000);
                check("gap_hold", {16'h0, sig0}, {16'h0, frozen});
                cyc(1'b0, 1'b1, 1'b0, 6'b100000);
                check("start_in_run", {28'h0, cnt0}, 32'd3);
            end
            cyc(1'b0, 1'b0, 1'b1, 6'b100000);
            if (i == 8) check("not_done_9", {31'h0, done0}, 32'd0);
        end
        check("done_10", {31'h0, done0}, 32'd1);
        check("count_10", {28'h0, cnt0}, 32'd10);
        expected = m_sig0;
        #1 check("match_eq", {31'h0, match0}, 32'd1);
        expected = m_sig0 ^ 16'h0001;
        #1 check("match_ne", {31'h0, match0}, 32'd0);
        frozen = sig0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 6'b111111);
        check("frozen", {16'h0, sig0}, {16'h0, frozen});

        // Restart from DONE with a coincident strobe.
        cyc(1'b0, 1'b1, 1'b1, 6'b000001);
        check("restart_sig", {16'h0, sig0}, 32'h0000);
        check("restart_cnt", {28'h0, cnt0}, 32'd0);

        // Reset after 4 samples.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 6'b010110);
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        check("rst_busy", {31'h0, busy0}, 32'd0);
        check("rst_sig", {16'h0, sig0}, 32'h0000);
        cyc(1'b0, 1'b0, 1'b0, 6'd0);

        // ackout edges in RUN without strobes.
        cyc(1'b0, 1'b1, 1'b0, 6'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 6'b100000);
            cyc(1'b0, 1'b0, 1'b0, 6'd0);
        end
`ifdef B06_MISR_EDGECNT_EN
        check("edges_3", {24'h0, edges0}, 32'd3);
`else
        check("edges_off", {24'h0, edges0}, 32'd0);
`endif
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 6'b100000);
            cyc(1'b0, 1'b0, 1'b0, 6'd0);
        end
`ifdef B06_MISR_EDGECNT_EN
        check("edges_sat", {24'h0, edges0}, 32'd255);
`else
        check("edges_off2", {24'h0, edges0}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
